// File: rtl/tx_scheduler.sv
// Round-robin scheduler sharing one byte-wide transmitter among four requesters.
// Issues a one-cycle start pulse, then tracks the transmitter busy/idle handshake.
module tx_scheduler #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  input  logic [7:0] data3,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [3:0] gnt,
  output logic [3:0] done,
  output logic       err,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

  state_e      state_q, state_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [3:0]  done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  win_q, win_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        pick_valid;
  logic [1:0]  pick_idx;
  logic [1:0]  cand;
  logic [7:0]  pick_data;
  logic        timeout_hit;

  // Search from the requester after the last winner, ascending with wrap.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last_q;
    cand       = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    pick_data = data0;
    unique case (pick_idx)
      2'd0: pick_data = data0;
      2'd1: pick_data = data1;
      2'd2: pick_data = data2;
      2'd3: pick_data = data3;
      default: pick_data = data0;
    endcase
  end

  assign timeout_hit = ({1'b0, cnt_q} + 5'd1) == 5'(TIMEOUT);

  always_comb begin
    state_d     = state_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    last_d      = last_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        gnt_d = '0;
        if (tx_ready && pick_valid) begin
          gnt_d      = 4'b0001 << pick_idx;
          tx_data_d  = pick_data;
          tx_start_d = 1'b1;
          win_d      = pick_idx;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (!tx_ready) begin
          cnt_d   = '0;
          state_d = StWaitDone;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          gnt_d   = '0;
          last_d  = win_q;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StWaitDone: begin
        if (tx_ready) begin
          done_d      = gnt_q;
          gnt_d       = '0;
          frame_cnt_d = frame_cnt_q + 8'd1;
          last_d      = win_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      last_q      <= 2'd3;
      win_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      last_q      <= last_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler: a frame-level reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_tx_scheduler;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] data [4];
  logic       tx_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       err;
  logic [7:0] frame_cnt;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  tx_scheduler #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data0    (data[0]),
    .data1    (data[1]),
    .data2    (data[2]),
    .data3    (data[3]),
    .tx_ready (tx_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Frame-level reference: who owns the transmitter and which handshake phase it is in.
  int         owner = -1;
  int         phase = 0;  // 0 free, 1 start issued, 2 awaiting busy, 3 awaiting idle
  int         last  = 3;
  int         waited = 0;
  int         frames = 0;
  logic [7:0] m_data = '0;
  logic [3:0] m_gnt  = '0;
  logic [3:0] m_done = '0;
  bit         m_start = 1'b0;
  bit         m_err   = 1'b0;

  always @(posedge clk) begin
    m_start = 1'b0;
    m_done  = '0;
    m_err   = 1'b0;
    if (rst) begin
      owner = -1; phase = 0; last = 3; waited = 0; frames = 0;
      m_data = '0; m_gnt = '0;
    end else if (phase == 0) begin
      m_gnt = '0;
      if (tx_ready) begin
        for (int k = 1; k <= 4; k++) begin
          if (owner < 0 && req[(last + k) % 4]) owner = (last + k) % 4;
        end
        if (owner >= 0) begin
          m_gnt = 4'(1 << owner); m_data = data[owner]; m_start = 1'b1; phase = 1;
        end
      end
    end else if (phase == 1) begin
      phase = 2; waited = 0;
    end else if (phase == 2) begin
      if (!tx_ready) phase = 3;
      else begin
        waited++;
        if (waited == TO) begin
          m_err = 1'b1; last = owner; owner = -1; m_gnt = '0; phase = 0;
        end
      end
    end else if (tx_ready) begin
      m_done = 4'(1 << owner); frames = (frames + 1) % 256;
      last = owner; owner = -1; m_gnt = '0; phase = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_start", 32'(tx_start), 32'(m_start));
      chk("tx_data", 32'(tx_data), 32'(m_data));
      chk("gnt", 32'(gnt), 32'(m_gnt));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("frame_cnt", 32'(frame_cnt), 32'(frames));
    end
  end

  task automatic bound_fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: event not seen within bound, expected it at %0t", name, $time);
  endtask

  task automatic wait_start(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (tx_start) ok = 1'b1;
    end
    if (!ok) bound_fail(name);
  endtask

  task automatic wait_end(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (done != 0 || err) ok = 1'b1;
    end
    if (!ok) bound_fail(name);
  endtask

  // Transmitter response after a start has been observed.
  task automatic transmit(input int drop, input int busy);
    repeat (drop) @(negedge clk);
    tx_ready = 1'b0;
    repeat (busy) @(negedge clk);
    tx_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    int starts;
    int gap;
    rst = 1'b1; req = '0; tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) data[i] = 8'hA0 + 8'(i);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_frame_cnt", 32'(frame_cnt), 0);
    chk("reset_tx_data", 32'(tx_data), 0);

    // Single request
    data[0] = 8'h06; req = 4'b0001;
    wait_start("single_start");
    chk("single_tx_data", 32'(tx_data), 32'h06);
    chk("single_gnt", 32'(gnt), 32'b0001);
    transmit(2, 10);
    wait_end("single_done");
    req = '0;
    chk("single_done_bit", 32'(done), 32'b0001);
    chk("single_frame_cnt", 32'(frame_cnt), 1);

    // Contention: round-robin order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 4; i++) data[i] = 8'h10 + 8'(i);
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_start("rr_start");
      chk("rr_gnt", 32'(gnt), 32'(1 << exp_ord[f]));
      chk("rr_tx_data", 32'(tx_data), 32'(8'h10 + 8'(exp_ord[f])));
      transmit(1, 3);
    end
    wait_end("rr_done");
    chk("rr_last_done", 32'(done), 32'b0001);
    chk("rr_frame_cnt", 32'(frame_cnt), 5);
    req = '0;

    // Timeout
    do_reset();
    req = 4'b0100;
    wait_start("to_start");
    chk("to_gnt", 32'(gnt), 32'b0100);
    gap = 0;
    for (int n = 0; n < 40 && !err; n++) begin
      @(negedge clk);
      gap++;
    end
    chk("to_gap", 32'(gap), 32'(TO + 1));
    chk("to_err", 32'(err), 1);
    chk("to_gnt_clear", 32'(gnt), 0);
    chk("to_no_done", 32'(done), 0);
    req = 4'b1111;
    @(negedge clk);
    chk("to_next_gnt", 32'(gnt), 32'b1000);
    chk("to_next_start", 32'(tx_start), 1);
    req = '0;

    // Reset mid-frame
    do_reset();
    req = 4'b0001;
    wait_start("mid_first");
    transmit(1, 2);
    wait_end("mid_first_done");
    wait_start("mid_second");
    @(negedge clk);
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_tx_start", 32'(tx_start), 0);
    chk("mid_gnt", 32'(gnt), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_frame_cnt", 32'(frame_cnt), 0);
    chk("mid_tx_data", 32'(tx_data), 0);
    req = 4'b0010; tx_ready = 1'b1;
    wait_start("mid_after");
    chk("mid_after_gnt", 32'(gnt), 32'b0010);
    req = '0;
    transmit(1, 1);
    wait_end("mid_after_done");

    // Blocked by busy transmitter
    do_reset();
    tx_ready = 1'b0; req = 4'b0001;
    starts = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_start) starts++;
    end
    chk("blocked_starts", 32'(starts), 0);
    chk("blocked_gnt", 32'(gnt), 0);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("blocked_release_start", 32'(tx_start), 1);
    req = '0;
    transmit(1, 2);
    wait_end("blocked_done");

    // Frame counter wrap
    do_reset();
    req = 4'b1111;
    for (int f = 0; f < 256; f++) begin
      wait_start("wrap_start");
      transmit(1, 1);
    end
    wait_end("wrap_done");
    req = '0;
    chk("wrap_frame_cnt", 32'(frame_cnt), 0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion by %0t", $time);
    $fatal(1);
  end

endmodule
